// File: rtl/fir_64_mdc_package.sv
// rtl/fir_64_mdc_package.sv - shared types for the fir_64_mdc job sequencer
//
// Purpose : state/status encodings and control/flag bundles used by the
//           job sequencer and the control register file.
// Contents: seq_state_t, seq_status_t, ctrl_seq_t, flags_seq_t.
package fir_64_mdc_package;

  localparam int unsigned SEQ_CNT_W = 32;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_FLUSH = 3'd4,
    S_DONE  = 3'd5
  } seq_state_t;

  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_TIMEOUT = 2'b01,
    ST_ABORT   = 2'b10,
    ST_ZLEN    = 2'b11
  } seq_status_t;

  typedef struct packed {
    logic                 trigger;
    logic [SEQ_CNT_W-1:0] len;
    logic                 abort;
  } ctrl_seq_t;

  typedef struct packed {
    logic                 busy;
    logic                 evt;
    seq_status_t          status;
    logic [SEQ_CNT_W-1:0] cnt_y;
  } flags_seq_t;

endpackage

// File: rtl/fir_64_mdc_seq_watchdog.sv
// rtl/fir_64_mdc_seq_watchdog.sv - output-inactivity watchdog for the job sequencer
//
// Purpose : counts enabled cycles without a kick and flags expiry.
// Ports   : clk_i, rst_i (sync, active-high)
//           clr_i    zero the counter (new job)
//           en_i     count this cycle (sequencer in RUN)
//           kick_i   output handshake seen; restarts the count
//           expire_o combinational: this cycle completes TIMEOUT-1 idle cycles
module fir_64_mdc_seq_watchdog #(
  parameter int unsigned TIMEOUT = 4096,
  parameter int unsigned TO_W    = 13
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  input  logic kick_i,
  output logic expire_o
);

  localparam bit              LP_ENABLED = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] LP_LAST    = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [TO_W-1:0] r_cnt;
  logic [TO_W-1:0] w_cnt_nxt;

  assign w_cnt_nxt = kick_i ? '0 : r_cnt + TO_W'(1);

  // Expiry looks at the value the counter is about to take, so the abort
  // decision lands in the same cycle the count reaches TIMEOUT-1.
  assign expire_o = LP_ENABLED & en_i & ~kick_i & (w_cnt_nxt == LP_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      r_cnt <= '0;
    end else if (en_i && LP_ENABLED) begin
      r_cnt <= w_cnt_nxt;
    end
  end

endmodule

// File: rtl/fir_64_mdc_job_sequencer.sv
// rtl/fir_64_mdc_job_sequencer.sv - job-level controller for the fir_64_mdc engine
//
// Purpose : launches a job of len samples, pulses engine clear/start, gates
//           the x_V stream to len beats, counts y_V beats to completion and
//           reports status plus a one-cycle end event.
// Ports   : clk_i, rst_i (sync, active-high)
//           trigger_i, len_i, abort_i       register-file job control
//           eng_ready_i, eng_start_o, eng_clear_o   engine ctrl/flags
//           x_valid_i, x_ready_i, x_en_o    x_V observe + gate
//           y_valid_i, y_ready_i            y_V observe
//           busy_o, evt_o, status_o, cnt_y_o        status to control slave
module fir_64_mdc_job_sequencer
  import fir_64_mdc_package::*;
#(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 4096,
  parameter int unsigned TO_W    = 13
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             trigger_i,
  input  logic [CNT_W-1:0] len_i,
  input  logic             abort_i,
  input  logic             eng_ready_i,
  output logic             eng_start_o,
  output logic             eng_clear_o,
  input  logic             x_valid_i,
  input  logic             x_ready_i,
  output logic             x_en_o,
  input  logic             y_valid_i,
  input  logic             y_ready_i,
  output logic             busy_o,
  output logic             evt_o,
  output logic [1:0]       status_o,
  output logic [CNT_W-1:0] cnt_y_o
);

  seq_state_t       r_state, w_state_nxt;
  seq_status_t      r_status, w_status_nxt;
  logic [CNT_W-1:0] r_len;
  logic [CNT_W-1:0] r_cnt_x;
  logic [CNT_W-1:0] r_cnt_y;

  logic w_accept;
  logic w_in_run;
  logic w_x_hs;
  logic w_y_hs;
  logic w_y_last;
  logic w_wd_expire;

  assign w_accept = (r_state == S_IDLE) & trigger_i;
  assign w_in_run = (r_state == S_RUN);
  assign w_x_hs   = x_valid_i & x_ready_i & x_en_o;
  // Output beats only count while the engine is running a job.
  assign w_y_hs   = w_in_run & y_valid_i & y_ready_i;
  assign w_y_last = w_y_hs & ((r_cnt_y + CNT_W'(1)) == r_len);

  fir_64_mdc_seq_watchdog #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_watchdog (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (w_accept),
    .en_i     (w_in_run),
    .kick_i   (w_y_hs),
    .expire_o (w_wd_expire)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_status_nxt = r_status;
    eng_start_o  = 1'b0;
    eng_clear_o  = 1'b0;
    x_en_o       = 1'b0;
    busy_o       = 1'b1;
    evt_o        = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy_o = 1'b0;
        if (trigger_i) begin
          if (len_i != '0) begin
            w_status_nxt = ST_OK;
            w_state_nxt  = S_CLEAR;
          end else begin
            w_status_nxt = ST_ZLEN;
            w_state_nxt  = S_DONE;
          end
        end
      end
      S_CLEAR: begin
        eng_clear_o = 1'b1;
        if (abort_i) begin
          w_status_nxt = ST_ABORT;
          w_state_nxt  = S_FLUSH;
        end else begin
          w_state_nxt  = S_START;
        end
      end
      S_START: begin
        // An abort here wins over a ready engine: never start a dropped job.
        if (abort_i) begin
          w_status_nxt = ST_ABORT;
          w_state_nxt  = S_FLUSH;
        end else if (eng_ready_i) begin
          eng_start_o = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        x_en_o = (r_cnt_x < r_len);
        if (w_y_last) begin
          w_status_nxt = ST_OK;
          w_state_nxt  = S_DONE;
        end else if (abort_i) begin
          w_status_nxt = ST_ABORT;
          w_state_nxt  = S_FLUSH;
        end else if (w_wd_expire) begin
          w_status_nxt = ST_TIMEOUT;
          w_state_nxt  = S_FLUSH;
        end
      end
      S_FLUSH: begin
        eng_clear_o = 1'b1;
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        evt_o       = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_status <= ST_OK;
      r_len    <= '0;
      r_cnt_x  <= '0;
      r_cnt_y  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_status <= w_status_nxt;
      if (w_accept) begin
        r_len   <= len_i;
        r_cnt_x <= '0;
        r_cnt_y <= '0;
      end else begin
        // x_en_o already blocks beats at len, so cnt_x saturates there.
        if (w_x_hs) begin
          r_cnt_x <= r_cnt_x + CNT_W'(1);
        end
        if (w_y_hs && (r_cnt_y != r_len)) begin
          r_cnt_y <= r_cnt_y + CNT_W'(1);
        end
      end
    end
  end

  assign status_o = r_status;
  assign cnt_y_o  = r_cnt_y;

endmodule

// File: tb/tb_fir_64_mdc_job_sequencer.sv
// tb/tb_fir_64_mdc_job_sequencer.sv - self-checking bench for fir_64_mdc_job_sequencer
module tb_fir_64_mdc_job_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        trigger_i = 1'b0;
  logic [31:0] len_i = '0;
  logic        abort_i = 1'b0;
  logic        eng_ready_i = 1'b0;
  logic        eng_start_o;
  logic        eng_clear_o;
  logic        x_valid_i = 1'b1;
  logic        x_ready_i = 1'b1;
  logic        x_en_o;
  logic        y_valid_i = 1'b1;
  logic        y_ready_i = 1'b1;
  logic        busy_o;
  logic        evt_o;
  logic [1:0]  status_o;
  logic [31:0] cnt_y_o;

  fir_64_mdc_job_sequencer #(
    .CNT_W   (32),
    .TIMEOUT (16),
    .TO_W    (5)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .trigger_i   (trigger_i),
    .len_i       (len_i),
    .abort_i     (abort_i),
    .eng_ready_i (eng_ready_i),
    .eng_start_o (eng_start_o),
    .eng_clear_o (eng_clear_o),
    .x_valid_i   (x_valid_i),
    .x_ready_i   (x_ready_i),
    .x_en_o      (x_en_o),
    .y_valid_i   (y_valid_i),
    .y_ready_i   (y_ready_i),
    .busy_o      (busy_o),
    .evt_o       (evt_o),
    .status_o    (status_o),
    .cnt_y_o     (cnt_y_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Event monitor, sampled mid-cycle on the falling edge.
  int n_x = 0, n_clr = 0, n_start = 0, n_evt = 0, n_xlate = 0;
  int last_clr_cyc = -1, last_start_cyc = -1, last_evt_cyc = -1;
  int b_x = 0, b_clr = 0, b_start = 0, b_evt = 0, b_xlate = 0;
  int x_lim = 32'h4000_0000;

  always @(negedge clk_i) begin
    if (x_en_o && ((n_x - b_x) >= x_lim)) n_xlate <= n_xlate + 1;
    if (x_valid_i && x_ready_i && x_en_o) n_x <= n_x + 1;
    if (eng_clear_o) begin n_clr <= n_clr + 1; last_clr_cyc <= cyc; end
    if (eng_start_o) begin n_start <= n_start + 1; last_start_cyc <= cyc; end
    if (evt_o) begin n_evt <= n_evt + 1; last_evt_cyc <= cyc; end
  end

  int n_tests = 0;
  int n_fail  = 0;
  int t0 = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic mark();
    b_x = n_x; b_clr = n_clr; b_start = n_start; b_evt = n_evt; b_xlate = n_xlate;
  endtask

  // Launch one job and run until its end event has passed and busy drops.
  // Offsets are cycles relative to the trigger cycle t0; -1 disables.
  task automatic run_job(input logic [31:0] len, input bit y_tog, input int rdy_dly,
                         input int y_stop, input int abort_at, input int retrig_at);
    bit ok;
    ok = 1'b0;
    mark();
    len_i = len;
    trigger_i = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 200; i++) begin
      eng_ready_i = ((cyc - t0) >= rdy_dly);
      if (y_stop >= 0 && (cyc - t0) > y_stop) y_ready_i = 1'b0;
      else y_ready_i = y_tog ? cyc[0] : 1'b1;
      abort_i = ((cyc - t0) == abort_at);
      if (i > 0) trigger_i = ((cyc - t0) == retrig_at);
      step();
      if ((n_evt != b_evt) && !busy_o) begin
        ok = 1'b1;
        break;
      end
    end
    trigger_i = 1'b0;
    abort_i = 1'b0;
    y_ready_i = 1'b1;
    chk("job_end_reached", ok, 1);
  endtask

  typedef struct {
    logic [31:0] len;
    bit          y_tog;
    int          rdy_dly;
    int          exp_x;
    int          exp_y;
    logic [1:0]  exp_status;
    int          exp_clr;
    int          exp_start;
    int          exp_start_dly;
  } vec_t;

  vec_t vecs [5];

  initial begin
    vecs[0] = '{len: 8, y_tog: 0, rdy_dly: 0, exp_x: 8, exp_y: 8, exp_status: 2'b00, exp_clr: 1, exp_start: 1, exp_start_dly: 2};
    vecs[1] = '{len: 1, y_tog: 0, rdy_dly: 0, exp_x: 1, exp_y: 1, exp_status: 2'b00, exp_clr: 1, exp_start: 1, exp_start_dly: 2};
    vecs[2] = '{len: 0, y_tog: 0, rdy_dly: 0, exp_x: 0, exp_y: 0, exp_status: 2'b11, exp_clr: 0, exp_start: 0, exp_start_dly: 0};
    vecs[3] = '{len: 3, y_tog: 1, rdy_dly: 0, exp_x: 3, exp_y: 3, exp_status: 2'b00, exp_clr: 1, exp_start: 1, exp_start_dly: 2};
    vecs[4] = '{len: 5, y_tog: 0, rdy_dly: 4, exp_x: 5, exp_y: 5, exp_status: 2'b00, exp_clr: 1, exp_start: 1, exp_start_dly: 4};

    // Reset state
    step();
    step();
    chk("rst_busy", busy_o, 0);
    chk("rst_evt", evt_o, 0);
    chk("rst_start", eng_start_o, 0);
    chk("rst_clear", eng_clear_o, 0);
    chk("rst_x_en", x_en_o, 0);
    chk("rst_status", status_o, 0);
    chk("rst_cnt_y", cnt_y_o, 0);
    rst_i = 1'b0;
    step();

    // Table-driven jobs
    foreach (vecs[k]) begin
      run_job(vecs[k].len, vecs[k].y_tog, vecs[k].rdy_dly, -1, -1, -1);
      chk($sformatf("v%0d_x_hs", k), n_x - b_x, vecs[k].exp_x);
      chk($sformatf("v%0d_cnt_y", k), cnt_y_o, vecs[k].exp_y);
      chk($sformatf("v%0d_status", k), status_o, vecs[k].exp_status);
      chk($sformatf("v%0d_clears", k), n_clr - b_clr, vecs[k].exp_clr);
      chk($sformatf("v%0d_starts", k), n_start - b_start, vecs[k].exp_start);
      chk($sformatf("v%0d_evts", k), n_evt - b_evt, 1);
      if (vecs[k].exp_clr != 0) begin
        chk($sformatf("v%0d_clr_cyc", k), last_clr_cyc - t0, 1);
        chk($sformatf("v%0d_start_cyc", k), last_start_cyc - t0, vecs[k].exp_start_dly);
      end else begin
        chk($sformatf("v%0d_evt_cyc", k), last_evt_cyc - t0, 1);
      end
      step();
    end

    // len=4 with a source that keeps offering beats: gate closes after 4
    x_lim = 4;
    run_job(4, 0, 0, -1, -1, -1);
    chk("gate_x_hs", n_x - b_x, 4);
    chk("gate_x_en_late", n_xlate - b_xlate, 0);
    chk("gate_status", status_o, 0);
    x_lim = 32'h4000_0000;
    step();

    // Timeout: last y beat at t0+5, flush clear expected at t0+21
    run_job(8, 0, 0, 5, -1, -1);
    chk("to_status", status_o, 2'b01);
    chk("to_cnt_y", cnt_y_o, 3);
    chk("to_clears", n_clr - b_clr, 2);
    chk("to_flush_cyc", last_clr_cyc - t0, 21);
    chk("to_evt_cyc", last_evt_cyc - t0, 22);
    chk("to_evts", n_evt - b_evt, 1);
    step(); step(); step();
    chk("idle_y_not_counted", cnt_y_o, 3);

    // Abort coinciding with the final y beat: completion wins
    run_job(2, 0, 0, -1, 4, -1);
    chk("abort_last_status", status_o, 2'b00);
    chk("abort_last_cnt_y", cnt_y_o, 2);
    chk("abort_last_clears", n_clr - b_clr, 1);
    step();

    // Abort mid-run, with a trigger during busy that must be ignored
    run_job(8, 0, 0, -1, 5, 4);
    chk("abort_mid_status", status_o, 2'b10);
    chk("abort_mid_cnt_y", cnt_y_o, 3);
    chk("abort_mid_x_hs", n_x - b_x, 3);
    chk("abort_mid_clears", n_clr - b_clr, 2);
    chk("abort_mid_starts", n_start - b_start, 1);
    chk("abort_mid_evts", n_evt - b_evt, 1);
    step();
    chk("retrig_ignored_busy", busy_o, 0);

    // Abort during CLEAR: no start, straight to flush
    run_job(8, 0, 0, -1, 1, -1);
    chk("abort_clr_status", status_o, 2'b10);
    chk("abort_clr_starts", n_start - b_start, 0);
    chk("abort_clr_clears", n_clr - b_clr, 2);
    chk("abort_clr_x_hs", n_x - b_x, 0);
    step();

    // Reset in the middle of RUN
    mark();
    len_i = 8;
    trigger_i = 1'b1;
    eng_ready_i = 1'b1;
    step();
    trigger_i = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("pre_rst_busy", busy_o, 1);
    rst_i = 1'b1;
    step();
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_x_en", x_en_o, 0);
    chk("mid_rst_clear", eng_clear_o, 0);
    chk("mid_rst_start", eng_start_o, 0);
    chk("mid_rst_evt", evt_o, 0);
    chk("mid_rst_status", status_o, 0);
    chk("mid_rst_cnt_y", cnt_y_o, 0);
    rst_i = 1'b0;
    step();
    chk("mid_rst_no_evt", n_evt - b_evt, 0);
    chk("mid_rst_one_clear", n_clr - b_clr, 1);

    run_job(8, 0, 0, -1, -1, -1);
    chk("post_rst_x_hs", n_x - b_x, 8);
    chk("post_rst_cnt_y", cnt_y_o, 8);
    chk("post_rst_status", status_o, 0);
    chk("post_rst_evts", n_evt - b_evt, 1);
    chk("post_rst_start_cyc", last_start_cyc - t0, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
